// File: rtl/wb_byte_master.sv
// wb_byte_master: byte-stream driven single-beat classic Wishbone initiator.
// Parses 'W' A3..A0 D3..D0 and 'R' A3..A0 frames (MSB first), runs one bus
// cycle per frame, and answers with a status byte (plus 4 data bytes on a
// successful read).
module wb_byte_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy_o
);

    localparam logic [7:0]  OP_WRITE  = 8'h57;
    localparam logic [7:0]  OP_READ   = 8'h52;
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_STATUS,
        S_RDATA
    } state_t;

    state_t      state_q, state_d;
    logic        run_q, run_d;       // low only while in reset, gates rx_ready_o
    logic        is_wr_q, is_wr_d;   // direction of the frame in progress
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;     // read data, shifted out MSB first
    logic [1:0]  cnt_q, cnt_d;       // byte index within a 4-byte field
    logic [15:0] tmo_q, tmo_d;       // cycles spent in BUS so far
    logic        ok_q, ok_d;         // 1 = ACK status, 0 = NAK status

    logic rx_fire;
    logic tx_fire;
    logic in_bus;

    assign in_bus     = (state_q == S_BUS);
    assign rx_ready_o = run_q & ((state_q == S_IDLE) |
                                 (state_q == S_ADDR) |
                                 (state_q == S_DATA));
    assign tx_valid_o = (state_q == S_STATUS) | (state_q == S_RDATA);
    assign rx_fire    = rx_valid_i & rx_ready_o;
    assign tx_fire    = tx_valid_o & tx_ready_i;

    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = wdat_q;
    assign wbm_cyc_o  = in_bus;
    assign wbm_stb_o  = in_bus;
    assign wbm_we_o   = in_bus & is_wr_q;
    assign wbm_sel_o  = in_bus ? 4'hF : 4'h0;
    assign busy_o     = (state_q != S_IDLE);

    // Response byte mux; data is a pure function of state so it stays stable under backpressure.
    always_comb begin
        tx_data_o = 8'h00;
        case (state_q)
            S_STATUS: tx_data_o = ok_q ? ACK_BYTE : NAK_BYTE;
            S_RDATA:  tx_data_o = rdat_q[31:24];
            default:  tx_data_o = 8'h00;
        endcase
    end

    // Next-state logic: frame parsing, bus cycle control and response sequencing.
    always_comb begin
        state_d = state_q;
        run_d   = 1'b1;
        is_wr_d = is_wr_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        ok_d    = ok_q;

        case (state_q)
            S_IDLE: begin
                // Unknown opcodes are swallowed so the parser resyncs on the next valid one.
                if (rx_fire) begin
                    cnt_d = 2'd0;
                    if (rx_data_i == OP_WRITE) begin
                        is_wr_d = 1'b1;
                        state_d = S_ADDR;
                    end else if (rx_data_i == OP_READ) begin
                        is_wr_d = 1'b0;
                        state_d = S_ADDR;
                    end
                end
            end

            S_ADDR: begin
                if (rx_fire) begin
                    adr_d = {adr_q[23:0], rx_data_i};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d = 2'd0;
                        tmo_d = 16'd0;
                        state_d = is_wr_q ? S_DATA : S_BUS;
                    end
                end
            end

            S_DATA: begin
                if (rx_fire) begin
                    wdat_d = {wdat_q[23:0], rx_data_i};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        tmo_d   = 16'd0;
                        state_d = S_BUS;
                    end
                end
            end

            S_BUS: begin
                // err beats ack; ack beats a timeout landing on the same edge.
                if (wbm_err_i) begin
                    ok_d    = 1'b0;
                    state_d = S_STATUS;
                end else if (wbm_ack_i) begin
                    ok_d    = 1'b1;
                    if (!is_wr_q) begin
                        rdat_d = wbm_dat_i;
                    end
                    state_d = S_STATUS;
                end else if ((tmo_q + 16'd1) == TMO_LIMIT) begin
                    ok_d    = 1'b0;
                    state_d = S_STATUS;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            S_STATUS: begin
                if (tx_fire) begin
                    cnt_d   = 2'd0;
                    state_d = (ok_q && !is_wr_q) ? S_RDATA : S_IDLE;
                end
            end

            S_RDATA: begin
                if (tx_fire) begin
                    rdat_d = {rdat_q[23:0], 8'h00};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial frame or pending response.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            is_wr_q <= 1'b0;
            adr_q   <= 32'h0;
            wdat_q  <= 32'h0;
            rdat_q  <= 32'h0;
            cnt_q   <= 2'd0;
            tmo_q   <= 16'd0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            is_wr_q <= is_wr_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            ok_q    <= ok_d;
        end
    end

endmodule

// File: tb/tb_wb_byte_master.sv
// Bench for wb_byte_master: table of frames against a parameterised slave
// model, a scoreboard queue for the response stream, plus hand-written
// sequences for reset values, minimum latency and reset during a bus cycle.
module tb_wb_byte_master;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_NONE = 2;
    localparam int M_BOTH = 3;

    logic        clk = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic        busy_o;

    wb_byte_master #(
        .TIMEOUT_CYCLES (8),
        .ACK_BYTE       (8'h06),
        .NAK_BYTE       (8'h15)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (wb_rst_ni),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic        garbage;
        logic        rand_tx;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          waits;
        int          mode;
        int          exp_cyc;
        logic [7:0]  exp_status;
    } vec_t;

    vec_t vecs [8];

    int n_cmp = 0;
    int n_bad = 0;

    // slave / monitor configuration and captures
    int          cfg_waits = 0;
    int          cfg_mode  = M_ACK;
    logic [31:0] cfg_rdat  = 32'h0;
    logic        cfg_rand  = 1'b0;
    int          cyc_total = 0;
    int          sig_bad   = 0;
    logic [31:0] cap_adr   = 32'h0;
    logic [31:0] cap_dat   = 32'h0;
    logic        cap_we    = 1'b0;

    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response sink: random or constant ready, compares each byte taken against the scoreboard.
    task automatic sink_loop();
        forever begin
            @(negedge clk);
            tx_ready_i = cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid_o && tx_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_extra: got byte %02h expected no byte", tx_data_o);
                end else begin
                    check("tx_byte", 64'(tx_data_o), 64'(exp_q.pop_front()));
                end
            end
        end
    endtask

    // Slave model and bus monitor: responds after cfg_waits cycles, counts cyc-high cycles.
    task automatic mon_loop();
        int   k;
        logic in_cyc;
        logic resp;
        k = 0;
        in_cyc = 1'b0;
        forever begin
            @(negedge clk);
            if (wbm_cyc_o) begin
                if (!in_cyc) begin
                    in_cyc  = 1'b1;
                    k       = 0;
                    cap_adr = wbm_adr_o;
                    cap_dat = wbm_dat_o;
                    cap_we  = wbm_we_o;
                end
                cyc_total++;
                if (!wbm_stb_o || wbm_sel_o != 4'hF) sig_bad++;
                resp      = (cfg_mode != M_NONE) && (k == cfg_waits);
                wbm_ack_i = resp && (cfg_mode == M_ACK || cfg_mode == M_BOTH);
                wbm_err_i = resp && (cfg_mode == M_ERR || cfg_mode == M_BOTH);
                wbm_dat_i = resp ? cfg_rdat : 32'h0;
                k++;
            end else begin
                in_cyc = 1'b0;
                if (wbm_stb_o || wbm_sel_o != 4'h0) sig_bad++;
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
                wbm_dat_i = 32'h0;
            end
        end
    endtask

    // Offers one byte starting at a negedge; returns at the negedge after it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        n = 0;
        while (!rx_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_stall: got rx_ready_o=0 for %0d cycles expected 1", n);
        end
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8]);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("frame_done", {62'h0, exp_q.size() != 0, busy_o}, 64'h0);
    endtask

    task automatic setup_slave(input vec_t v);
        cfg_waits = v.waits;
        cfg_mode  = v.mode;
        cfg_rdat  = v.rdat;
        cfg_rand  = v.rand_tx;
    endtask

    task automatic push_expected(input vec_t v);
        exp_q.push_back(v.exp_status);
        if (v.exp_status == 8'h06 && !v.is_wr) begin
            for (int i = 3; i >= 0; i--) exp_q.push_back(v.rdat[i*8 +: 8]);
        end
    endtask

    task automatic send_frame(input vec_t v);
        if (v.garbage) begin
            send_byte(8'h00);
            send_byte(8'hFF);
            send_byte(8'h41);
        end
        send_byte(v.is_wr ? 8'h57 : 8'h52);
        send_word(v.adr);
        if (v.is_wr) send_word(v.wdat);
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        int c0;
        int s0;
        setup_slave(v);
        push_expected(v);
        c0 = cyc_total;
        s0 = sig_bad;
        send_frame(v);
        wait_done();
        check($sformatf("v%0d_cyc_len", idx), 64'(cyc_total - c0), 64'(v.exp_cyc));
        check($sformatf("v%0d_adr", idx), 64'(cap_adr), 64'(v.adr));
        check($sformatf("v%0d_we", idx), 64'(cap_we), 64'(v.is_wr));
        if (v.is_wr) check($sformatf("v%0d_wdat", idx), 64'(cap_dat), 64'(v.wdat));
        check($sformatf("v%0d_stb_sel", idx), 64'(sig_bad - s0), 64'h0);
    endtask

    initial begin
        vec_t lat;
        int   c0;

        //            wr    garb  rand  adr           wdat          rdat          wt mode    cyc status
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h3000_1004, 32'h0000_002A, 32'h0,        3, M_ACK,  4, 8'h06};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h3000_0000, 32'h0,        32'hDEAD_BEEF, 0, M_ACK,  1, 8'h06};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h3000_0040, 32'h0,        32'h1111_2222, 0, M_NONE, 8, 8'h15};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h3000_2008, 32'hCAFE_F00D, 32'h0,        0, M_BOTH, 1, 8'h15};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h3000_0010, 32'h0,        32'h1234_5678, 2, M_ACK,  3, 8'h06};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h3000_3FFC, 32'h0,        32'hA5C3_0F96, 1, M_ACK,  2, 8'h06};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h3000_0500, 32'h8000_0001, 32'h0,        5, M_ERR,  6, 8'h15};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h3000_0A0C, 32'h0,        32'h0F1E_2D3C, 7, M_ACK,  8, 8'h06};

        fork
            sink_loop();
            mon_loop();
        join_none

        // reset values while held in reset
        repeat (3) @(negedge clk);
        check("rst_ctrl", {54'h0, rx_ready_o, tx_valid_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, busy_o}, 64'h0);
        check("rst_tx_data", 64'(tx_data_o), 64'h0);
        check("rst_adr_dat", {wbm_adr_o, wbm_dat_o}, 64'h0);
        wb_rst_ni = 1'b1;
        @(negedge clk);
        check("rx_ready_after_rst", 64'(rx_ready_o), 64'h1);

        for (int i = 0; i < 8; i++) begin
            run_frame(i, vecs[i]);
        end

        // minimum latency: zero-wait ack, status valid two edges after the last byte
        lat = vecs[1];
        lat.rdat = 32'h0BAD_F00D;
        setup_slave(lat);
        push_expected(lat);
        c0 = cyc_total;
        send_frame(lat);
        check("lat_cyc_after_last", {62'h0, wbm_cyc_o, tx_valid_o}, 64'h2);
        @(negedge clk);
        check("lat_status_valid", {62'h0, wbm_cyc_o, tx_valid_o}, 64'h1);
        wait_done();
        check("lat_cyc_len", 64'(cyc_total - c0), 64'h1);

        // reset asserted while the bus cycle is open (slave silent)
        cfg_mode = M_NONE;
        cfg_rand = 1'b0;
        send_frame(vecs[2]);
        repeat (2) @(negedge clk);
        check("pre_rst_cyc", 64'(wbm_cyc_o), 64'h1);
        #2;
        wb_rst_ni = 1'b0;
        #1;
        check("midrst_ctrl", {54'h0, rx_ready_o, tx_valid_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, busy_o}, 64'h0);
        check("midrst_tx_data", 64'(tx_data_o), 64'h0);
        check("midrst_adr_dat", {wbm_adr_o, wbm_dat_o}, 64'h0);
        repeat (2) @(negedge clk);
        wb_rst_ni = 1'b1;
        @(negedge clk);
        check("rx_ready_after_midrst", 64'(rx_ready_o), 64'h1);
        run_frame(8, vecs[1]);
        run_frame(9, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 ns expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
